// File: rtl/timed_imem.sv
// timed_imem: writable instruction memory with a wait-state ihit handshake, a program-load port and fault flagging.
// Optional macro TIMED_IMEM_ADDR_RESTART_EN: an imemaddr change during BUSY restarts the fetch.
module timed_imem #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        ifault,
    input  logic        prog_wen,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   mem [DEPTH];

    logic          req_in_range;
    logic          req_fault;
    logic          prog_in_range;
    logic          restart;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] prog_idx;
    logic          unused_prog_lsbs;

    assign req_in_range     = {2'b00, req_addr_q[31:2]} < 32'(DEPTH);
    assign req_fault        = (req_addr_q[1:0] != 2'b00) || !req_in_range;
    assign req_idx          = req_addr_q[AW+1:2];
    assign prog_in_range    = {2'b00, prog_addr[31:2]} < 32'(DEPTH);
    assign prog_idx         = prog_addr[AW+1:2];
    assign unused_prog_lsbs = ^prog_addr[1:0];

    // A redirect only matters while BUSY; it suppresses that cycle's hit.
`ifdef TIMED_IMEM_ADDR_RESTART_EN
    assign restart = (imemaddr != req_addr_q);
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Array contents survive reset so a program can be loaded before or during it.
    always_ff @(posedge CLK) begin
        if (prog_wen && prog_in_range) begin
            mem[prog_idx] <= prog_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        ihit       = 1'b0;
        ifault     = 1'b0;
        imemload   = '0;
        case (state_q)
            IDLE: begin
                if (iREN) begin
                    state_d    = BUSY;
                    req_addr_d = imemaddr;
                    cnt_d      = CW'(WAIT_CYCLES);
                end
            end
            BUSY: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (restart) begin
                    req_addr_d = imemaddr;
                    cnt_d      = CW'(WAIT_CYCLES);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d  = IDLE;
                    ihit     = 1'b1;
                    ifault   = req_fault;
                    imemload = req_fault ? 32'h0000_0000 : mem[req_idx];
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
